// File: rtl/alu_branch_ctrl.sv
// alu_branch_ctrl: registered decode/execute slice of an RV32I core.
// Decodes the instruction, runs the ALU on the selected operands, evaluates
// the branch condition and forms the next PC. Every output is registered
// once; an asynchronous reset clears them all.
module alu_branch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic        branch,
  output logic [31:0] pc_next,
  output logic        reg_write_en,
  output logic [1:0]  rd_src,
  output logic        data_read_en,
  output logic        data_write_en,
  output logic [2:0]  data_size,
  output logic [3:0]  alu_op,
  output logic        alu_a_src,
  output logic        alu_b_src,
  output logic [2:0]  branch_cond
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] BR_ALWAYS = 3'b011;
  localparam logic [2:0] BR_NEVER  = 3'b010;

  // ALU: shifts use only the low five bits of b; unknown codes add.
  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = a;
    b_s = b;
    case (op)
      4'b0000: alu_calc = a + b;
      4'b1000: alu_calc = a - b;
      4'b0001: alu_calc = a << b[4:0];
      4'b0010: alu_calc = (a_s < b_s) ? 32'd1 : 32'd0;
      4'b0011: alu_calc = (a < b) ? 32'd1 : 32'd0;
      4'b0100: alu_calc = a ^ b;
      4'b0101: alu_calc = a >> b[4:0];
      4'b1101: alu_calc = a_s >>> b[4:0];
      4'b0110: alu_calc = a | b;
      4'b0111: alu_calc = a & b;
      4'b1010: alu_calc = b;
      default: alu_calc = a + b;
    endcase
  endfunction

  // Branch comparator on the raw register operands.
  function automatic logic branch_eval(input logic [2:0]  cond,
                                       input logic [31:0] r1,
                                       input logic [31:0] r2);
    logic signed [31:0] r1_s;
    logic signed [31:0] r2_s;
    r1_s = r1;
    r2_s = r2;
    case (cond)
      3'b000:  branch_eval = (r1 == r2);
      3'b001:  branch_eval = (r1 != r2);
      3'b100:  branch_eval = (r1_s < r2_s);
      3'b101:  branch_eval = (r1_s >= r2_s);
      3'b110:  branch_eval = (r1 < r2);
      3'b111:  branch_eval = (r1 >= r2);
      3'b011:  branch_eval = 1'b1;
      default: branch_eval = 1'b0;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        bit30;
  logic        unused_instr;

  logic        reg_write_en_p0;
  logic [1:0]  rd_src_p0;
  logic        data_read_en_p0;
  logic        data_write_en_p0;
  logic [3:0]  alu_op_p0;
  logic        alu_a_src_p0;
  logic        alu_b_src_p0;
  logic [2:0]  branch_cond_p0;
  logic [31:0] alu_a_p0;
  logic [31:0] alu_b_p0;
  logic [31:0] alu_out_p0;
  logic        branch_p0;
  logic [31:0] pc_next_p0;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign bit30        = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Control decode; anything unrecognised becomes a NOP.
  always_comb begin
    reg_write_en_p0  = 1'b0;
    rd_src_p0        = 2'b00;
    data_read_en_p0  = 1'b0;
    data_write_en_p0 = 1'b0;
    alu_op_p0        = ALU_ADD;
    alu_a_src_p0     = 1'b0;
    alu_b_src_p0     = 1'b0;
    branch_cond_p0   = BR_NEVER;
    case (opcode)
      OP_R: begin
        reg_write_en_p0 = 1'b1;
        alu_a_src_p0    = 1'b1;
        alu_b_src_p0    = 1'b1;
        alu_op_p0       = {bit30, funct3};
      end
      OP_I: begin
        reg_write_en_p0 = 1'b1;
        alu_a_src_p0    = 1'b1;
        // Only SRAI borrows bit 30; for the rest it is immediate data.
        alu_op_p0       = {(funct3 == 3'b101) ? bit30 : 1'b0, funct3};
      end
      OP_LOAD: begin
        reg_write_en_p0 = 1'b1;
        alu_a_src_p0    = 1'b1;
        rd_src_p0       = 2'b01;
        data_read_en_p0 = 1'b1;
      end
      OP_STORE: begin
        alu_a_src_p0     = 1'b1;
        data_write_en_p0 = 1'b1;
      end
      OP_BRANCH: begin
        branch_cond_p0 = funct3;
      end
      OP_JAL: begin
        reg_write_en_p0 = 1'b1;
        branch_cond_p0  = BR_ALWAYS;
        rd_src_p0       = 2'b10;
      end
      OP_JALR: begin
        reg_write_en_p0 = 1'b1;
        alu_a_src_p0    = 1'b1;
        branch_cond_p0  = BR_ALWAYS;
        rd_src_p0       = 2'b10;
      end
      OP_LUI: begin
        reg_write_en_p0 = 1'b1;
        alu_op_p0       = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_write_en_p0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_a_p0   = alu_a_src_p0 ? rs1_value : pc;
  assign alu_b_p0   = alu_b_src_p0 ? rs2_value : imm;
  assign alu_out_p0 = alu_calc(alu_op_p0, alu_a_p0, alu_b_p0);
  assign branch_p0  = branch_eval(branch_cond_p0, rs1_value, rs2_value);
  assign pc_next_p0 = branch_p0 ? {alu_out_p0[31:1], 1'b0} : pc + 32'd4;

  // ---- stage p0 -> outputs: capture every cycle, cleared asynchronously ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out       <= '0;
      branch        <= 1'b0;
      pc_next       <= '0;
      reg_write_en  <= 1'b0;
      rd_src        <= '0;
      data_read_en  <= 1'b0;
      data_write_en <= 1'b0;
      data_size     <= '0;
      alu_op        <= '0;
      alu_a_src     <= 1'b0;
      alu_b_src     <= 1'b0;
      branch_cond   <= '0;
    end else begin
      alu_out       <= alu_out_p0;
      branch        <= branch_p0;
      pc_next       <= pc_next_p0;
      reg_write_en  <= reg_write_en_p0;
      rd_src        <= rd_src_p0;
      data_read_en  <= data_read_en_p0;
      data_write_en <= data_write_en_p0;
      data_size     <= funct3;
      alu_op        <= alu_op_p0;
      alu_a_src     <= alu_a_src_p0;
      alu_b_src     <= alu_b_src_p0;
      branch_cond   <= branch_cond_p0;
    end
  end

endmodule

// File: tb/tb_alu_branch_ctrl.sv
// Scoreboard bench for alu_branch_ctrl: directed vectors push hand-computed
// expected outputs into a queue; a monitor pops and compares after each edge.
module tb_alu_branch_ctrl;

  typedef struct packed {
    logic [31:0] alu_out;
    logic        branch;
    logic [31:0] pc_next;
    logic        reg_write_en;
    logic [1:0]  rd_src;
    logic        data_read_en;
    logic        data_write_en;
    logic [2:0]  data_size;
    logic [3:0]  alu_op;
    logic        alu_a_src;
    logic        alu_b_src;
    logic [2:0]  branch_cond;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr, pc, rs1_value, rs2_value, imm;
  logic [31:0] alu_out;
  logic        branch;
  logic [31:0] pc_next;
  logic        reg_write_en;
  logic [1:0]  rd_src;
  logic        data_read_en, data_write_en;
  logic [2:0]  data_size;
  logic [3:0]  alu_op;
  logic        alu_a_src, alu_b_src;
  logic [2:0]  branch_cond;

  exp_t  act;
  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  alu_branch_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .imm(imm),
    .alu_out(alu_out), .branch(branch), .pc_next(pc_next),
    .reg_write_en(reg_write_en), .rd_src(rd_src),
    .data_read_en(data_read_en), .data_write_en(data_write_en),
    .data_size(data_size), .alu_op(alu_op), .alu_a_src(alu_a_src),
    .alu_b_src(alu_b_src), .branch_cond(branch_cond)
  );

  assign act = '{alu_out, branch, pc_next, reg_write_en, rd_src, data_read_en,
                 data_write_en, data_size, alu_op, alu_a_src, alu_b_src, branch_cond};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] ao, input logic br, input logic [31:0] pcn,
                              input logic we, input logic [1:0] rds, input logic rde,
                              input logic wre, input logic [2:0] ds, input logic [3:0] op,
                              input logic as, input logic bs, input logic [2:0] bc);
    mk = '{ao, br, pcn, we, rds, rde, wre, ds, op, as, bs, bc};
  endfunction

  task automatic issue(input string nm, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input exp_t e);
    @(negedge clk);
    instr = i; pc = p; rs1_value = r1; rs2_value = r2; imm = im;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required all zero", nm, act);
    end
  endtask

  // Monitor: one expected entry is consumed per captured instruction.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got alu=%h br=%b pcn=%h we=%b rds=%b rd=%b wr=%b sz=%b op=%b a=%b b=%b bc=%b ; want alu=%h br=%b pcn=%h we=%b rds=%b rd=%b wr=%b sz=%b op=%b a=%b b=%b bc=%b",
                   n, act.alu_out, act.branch, act.pc_next, act.reg_write_en, act.rd_src,
                   act.data_read_en, act.data_write_en, act.data_size, act.alu_op,
                   act.alu_a_src, act.alu_b_src, act.branch_cond,
                   e.alu_out, e.branch, e.pc_next, e.reg_write_en, e.rd_src,
                   e.data_read_en, e.data_write_en, e.data_size, e.alu_op,
                   e.alu_a_src, e.alu_b_src, e.branch_cond);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    instr = '0; pc = '0; rs1_value = '0; rs2_value = '0; imm = '0;

    issue("add", 32'h002081B3, 32'h10, 32'd5, 32'd7, 32'h0,
          mk(32'd12, 0, 32'h14, 1, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 1, 3'b010));

    // Asynchronous reset with nonzero inputs; the in-flight SUB is discarded.
    @(negedge clk);
    instr = 32'h402081B3; rs1_value = 32'hFFFFFFF0; rs2_value = 32'd4;
    #2 reset = 1'b1;
    #1 check_zero("reset_async");
    @(posedge clk);
    #1 check_zero("reset_held");
    #2 reset = 1'b0;

    issue("sub", 32'h402081B3, 32'h10, 32'hFFFFFFF0, 32'd4, 32'h0,
          mk(32'hFFFFFFEC, 0, 32'h14, 1, 2'b00, 0, 0, 3'b000, 4'b1000, 1, 1, 3'b010));
    issue("sra", 32'h4020D1B3, 32'h10, 32'hFFFFFFF0, 32'd4, 32'h0,
          mk(32'hFFFFFFFF, 0, 32'h14, 1, 2'b00, 0, 0, 3'b101, 4'b1101, 1, 1, 3'b010));
    issue("slt", 32'h0020A1B3, 32'h10, 32'hFFFFFFF0, 32'd4, 32'h0,
          mk(32'd1, 0, 32'h14, 1, 2'b00, 0, 0, 3'b010, 4'b0010, 1, 1, 3'b010));
    issue("sltu", 32'h0020B1B3, 32'h10, 32'hFFFFFFF0, 32'd4, 32'h0,
          mk(32'd0, 0, 32'h14, 1, 2'b00, 0, 0, 3'b011, 4'b0011, 1, 1, 3'b010));
    issue("undef_op_adds", 32'h402091B3, 32'h10, 32'hFFFFFFF0, 32'd4, 32'h0,
          mk(32'hFFFFFFF4, 0, 32'h14, 1, 2'b00, 0, 0, 3'b001, 4'b1001, 1, 1, 3'b010));
    issue("sll_low5", 32'h002091B3, 32'h10, 32'd1, 32'h24, 32'h0,
          mk(32'h10, 0, 32'h14, 1, 2'b00, 0, 0, 3'b001, 4'b0001, 1, 1, 3'b010));
    issue("srai", 32'h4040D193, 32'h10, 32'hFFFFFFF0, 32'd0, 32'h404,
          mk(32'hFFFFFFFF, 0, 32'h14, 1, 2'b00, 0, 0, 3'b101, 4'b1101, 1, 0, 3'b010));
    issue("srli", 32'h0040D193, 32'h10, 32'hFFFFFFF0, 32'd0, 32'h4,
          mk(32'h0FFFFFFF, 0, 32'h14, 1, 2'b00, 0, 0, 3'b101, 4'b0101, 1, 0, 3'b010));
    issue("addi_neg", 32'hC0008193, 32'h10, 32'h1000, 32'd0, 32'hFFFFFC00,
          mk(32'h00000C00, 0, 32'h14, 1, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 0, 3'b010));
    issue("add_pc_wrap", 32'h002081B3, 32'hFFFFFFFC, 32'd1, 32'd2, 32'h0,
          mk(32'd3, 0, 32'h0, 1, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 1, 3'b010));
    issue("beq_taken", 32'h00208063, 32'h100, 32'd9, 32'd9, 32'hFFFFFFF8,
          mk(32'hF8, 1, 32'hF8, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 0, 3'b000));
    issue("beq_not", 32'h00208063, 32'h100, 32'd9, 32'd10, 32'hFFFFFFF8,
          mk(32'hF8, 0, 32'h104, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 0, 3'b000));
    issue("bne_not", 32'h00209063, 32'h100, 32'd3, 32'd3, 32'h10,
          mk(32'h110, 0, 32'h104, 0, 2'b00, 0, 0, 3'b001, 4'b0000, 0, 0, 3'b001));
    issue("blt_taken", 32'h0020C063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h10,
          mk(32'h110, 1, 32'h110, 0, 2'b00, 0, 0, 3'b100, 4'b0000, 0, 0, 3'b100));
    issue("bltu_not", 32'h0020E063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h10,
          mk(32'h110, 0, 32'h104, 0, 2'b00, 0, 0, 3'b110, 4'b0000, 0, 0, 3'b110));
    issue("bgeu_taken", 32'h0020F063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h10,
          mk(32'h110, 1, 32'h110, 0, 2'b00, 0, 0, 3'b111, 4'b0000, 0, 0, 3'b111));
    issue("jalr", 32'h000280E7, 32'h50, 32'h203, 32'd0, 32'h0,
          mk(32'h203, 1, 32'h202, 1, 2'b10, 0, 0, 3'b000, 4'b0000, 1, 0, 3'b011));
    issue("jal", 32'h020000EF, 32'h40, 32'd0, 32'd0, 32'h20,
          mk(32'h60, 1, 32'h60, 1, 2'b10, 0, 0, 3'b000, 4'b0000, 0, 0, 3'b011));
    issue("lw", 32'h0040A183, 32'h60, 32'h1000, 32'd0, 32'h4,
          mk(32'h1004, 0, 32'h64, 1, 2'b01, 1, 0, 3'b010, 4'b0000, 1, 0, 3'b010));
    issue("sb", 32'h00208023, 32'h64, 32'h2000, 32'h55, 32'h0,
          mk(32'h2000, 0, 32'h68, 0, 2'b00, 0, 1, 3'b000, 4'b0000, 1, 0, 3'b010));
    issue("lui", 32'h123451B7, 32'h80, 32'h7, 32'h9, 32'h12345000,
          mk(32'h12345000, 0, 32'h84, 1, 2'b00, 0, 0, 3'b101, 4'b1010, 0, 0, 3'b010));
    issue("auipc", 32'h00001197, 32'h80, 32'h7, 32'h9, 32'h1000,
          mk(32'h1080, 0, 32'h84, 1, 2'b00, 0, 0, 3'b001, 4'b0000, 0, 0, 3'b010));
    issue("nop_opcode0", 32'h00000000, 32'h200, 32'd5, 32'd7, 32'h3,
          mk(32'h203, 0, 32'h204, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 0, 3'b010));

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_branch_ctrl.md
# alu_branch_ctrl

Registered decode/execute slice of the single-cycle RV32I core. It merges the control unit, ALU and branch comparator: it decodes `instr`, computes the ALU result from register/PC/immediate operands, and evaluates branch/jump conditions. It also forms the next PC. All results appear on registered outputs one clock after the inputs are presented. It sits between the register file/immediate generator and the data-memory/IO/PC-update logic.

## Interface
Parameters: none (fixed 32-bit, RV32I).
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high; clears all outputs
- `instr` in 32: instruction word
- `pc` in 32: address of `instr`
- `rs1_value`, `rs2_value` in 32 each: register operands
- `imm` in 32: sign-extended immediate for `instr`
- `alu_out` out 32: ALU result (data address, writeback value or jump target)
- `branch` out 1: taken flag (branch condition true, or JAL/JALR)
- `pc_next` out 32: next PC
- `reg_write_en` out 1: write rd
- `rd_src` out 2: 00 = alu_out, 01 = memory/IO data, 10 = pc+4
- `data_read_en`, `data_write_en` out 1 each: load/store strobes
- `data_size` out 3: funct3 of the load/store
- `alu_op` out 4, `alu_a_src` out 1, `alu_b_src` out 1, `branch_cond` out 3: decoded controls, for observation

## Operation
Decode uses `opcode = instr[6:0]`, `funct3 = instr[14:12]` and `instr[30]`.
- Operand A: `alu_a_src` = 1 selects rs1_value, 0 selects pc.
- Operand B: `alu_b_src` = 1 selects rs2_value, 0 selects imm.

ALU (`alu_op`):
- 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1010 pass B.
- Shifts use only b[4:0]. SLT/SLTU produce 1 or 0.
- Undefined codes produce ADD.

Branch (`branch_cond`):
- 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU, compared as rs1_value vs rs2_value.
- 011 always taken; 010 never taken; other codes never taken.

Decode per opcode (reg_write_en / a_src / b_src / alu_op / branch_cond / rd_src / rd_en / wr_en):
- 0110011 R: 1 / rs1 / rs2 / {instr[30],funct3} / never / 00 / 0 / 0
- 0010011 I-ALU: 1 / rs1 / imm / {funct3==101 ? instr[30] : 0, funct3} / never / 00 / 0 / 0
- 0000011 load: 1 / rs1 / imm / ADD / never / 01 / 1 / 0
- 0100011 store: 0 / rs1 / imm / ADD / never / 00 / 0 / 1
- 1100011 branch: 0 / pc / imm / ADD / funct3 / 00 / 0 / 0
- 1101111 JAL: 1 / pc / imm / ADD / always / 10 / 0 / 0
- 1100111 JALR: 1 / rs1 / imm / ADD / always / 10 / 0 / 0
- 0110111 LUI: 1 / pc / imm / pass B / never / 00 / 0 / 0
- 0010111 AUIPC: 1 / pc / imm / ADD / never / 00 / 0 / 0
- Any other opcode (incl. FENCE, SYSTEM) is a NOP: all enables 0, ADD, never, rd_src 00.

Other outputs:
- `data_size` = funct3 for every opcode.
- `pc_next` = branch ? {alu_out[31:1],1'b0} : pc+4. Arithmetic is modulo 2^32.
- rd = x0 is not special-cased here.

## Timing
- The combinational result is captured into all outputs on each rising `clk`. Latency is 1 cycle; throughput is one instruction per cycle; there is no handshake.
- `reset` asserted: all outputs are 0 immediately, independent of the clock, and stay 0 while asserted.
- The first capture occurs on the first rising edge after `reset` deasserts.
- Reset mid-stream discards the in-flight result.

## Test plan
- `reset` pulse with nonzero inputs -> all outputs 0 with no clock edge; the next edge after release captures normally.
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, pc = 0x10 -> after one edge: alu_out = 12, reg_write_en = 1, rd_src = 00, branch = 0, pc_next = 0x14.
- SUB/SRA/SLT/SLTU with rs1 = 0xFFFFFFF0, rs2 = 4 -> respectively 0xFFFFFFEC, 0xFFFFFFFF, 1, 0; SRAI vs SRLI by 4 -> 0xFFFFFFFF vs 0x0FFFFFFF.
- BEQ with pc = 0x100, imm = −8: rs1 = rs2 -> branch = 1, pc_next = 0xF8. rs1 ≠ rs2 -> branch = 0, pc_next = 0x104. BLT vs BLTU with rs1 = −1, rs2 = 1 -> taken vs not taken.
- JALR with rs1 = 0x203, imm = 0 -> branch = 1, pc_next = 0x202, rd_src = 10. JAL with pc = 0x40, imm = 0x20 -> pc_next = 0x60.
- LW (rs1 = 0x1000, imm = 4) -> alu_out = 0x1004, data_read_en = 1, data_size = 010, rd_src = 01. SB -> data_write_en = 1, reg_write_en = 0, data_size = 000. LUI imm = 0x12345000 -> alu_out = 0x12345000. Opcode 0x00 -> all enables 0.
